// File: rtl/aabb_exit_stepper_if.sv
// rtl/aabb_exit_stepper_if.sv - ray request/result handshake bundle for the AABB exit stepper
interface aabb_exit_stepper_if #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 8,
    parameter int CW    = $clog2(WIDTH + 3)
);
    logic                   in_valid;
    logic                   in_ready;
    logic [2:0][WIDTH-1:0]  in_q;
    logic [2:0][WIDTH-1:0]  in_v;
    logic [2:0][WIDTH-1:0]  in_l;
    logic [2:0][WIDTH-1:0]  in_u;
    logic [TAG_W-1:0]       in_tag;

    logic                   out_valid;
    logic                   out_ready;
    logic [2:0][WIDTH-1:0]  out_qp;
    logic [TAG_W-1:0]       out_tag;
    logic [2:0]             out_face;
    logic                   out_oob;
    logic                   out_timeout;
    logic [CW-1:0]          out_iters;

    // Requester side: issues rays, consumes results.
    modport master (
        output in_valid, in_q, in_v, in_l, in_u, in_tag, out_ready,
        input  in_ready, out_valid, out_qp, out_tag, out_face, out_oob, out_timeout, out_iters
    );

    // Stepper side.
    modport slave (
        input  in_valid, in_q, in_v, in_l, in_u, in_tag, out_ready,
        output in_ready, out_valid, out_qp, out_tag, out_face, out_oob, out_timeout, out_iters
    );
endinterface

// File: rtl/aabb_exit_stepper.sv
// rtl/aabb_exit_stepper.sv - binary-halving ray stepper that finds where a ray leaves an axis-aligned box
module aabb_exit_stepper #(
    parameter int WIDTH    = 16,
    parameter int TAG_W    = 8,
    parameter int MAX_ITER = WIDTH + 2,
    parameter int CW       = $clog2(MAX_ITER + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    aabb_exit_stepper_if.slave   bus
);
    // Proposed positions carry two extra bits so that one step below zero
    // or one step past the top of the coordinate range is representable.
    localparam int PW = WIDTH + 2;
    localparam logic [PW-1:0] P_ONE    = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_ITER - 1);

    typedef enum logic [1:0] {IDLE, STEP, DONE} state_t;

    state_t                 state;
    logic [2:0][WIDTH-1:0]  acc;
    logic [2:0][WIDTH:0]    s;
    logic [2:0][WIDTH-1:0]  l_r;
    logic [2:0][WIDTH-1:0]  u_r;
    logic [TAG_W-1:0]       tag_r;
    logic [CW-1:0]          count;

    logic [2:0][WIDTH-1:0]  rs;
    logic [2:0][PW-1:0]     p;
    logic [2:0][PW-1:0]     lo;
    logic [2:0][PW-1:0]     hi;
    logic [2:0]             ax_in;
    logic [2:0]             ax_on;
    logic [2:0]             ax_hi;
    logic [2:0][WIDTH-1:0]  acc_nxt;
    logic                   in_box;
    logic                   hit;
    logic                   last_iter;
    logic                   oob;
    logic [1:0]             face_axis;
    logic                   face_side;

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);

    // One halving step per axis: propose a move, classify it against the expanded box.
    always_comb begin
        in_box    = 1'b1;
        oob       = 1'b0;
        face_axis = 2'd3;
        face_side = 1'b0;
        for (int i = 0; i < 3; i++) begin
            // s/2 rounded toward zero: floor shift, then fix up negative odd values.
            rs[i]    = s[i][WIDTH:1] + {{(WIDTH-1){1'b0}}, s[i][WIDTH] & s[i][0]};
            p[i]     = {2'b00, acc[i]} + {{2{rs[i][WIDTH-1]}}, rs[i]};
            lo[i]    = {2'b00, l_r[i]} - P_ONE;
            hi[i]    = {2'b00, u_r[i]} + P_ONE;
            ax_hi[i] = (p[i] == hi[i]);
            ax_on[i] = (p[i] == lo[i]) || ax_hi[i];
            ax_in[i] = ($signed(p[i]) >= $signed(lo[i])) && ($signed(p[i]) <= $signed(hi[i]));
            in_box   = in_box & ax_in[i];
            oob      = oob | (p[i][PW-1:WIDTH] != 2'b00);
        end
        for (int i = 2; i >= 0; i--) begin
            if (ax_on[i]) begin
                face_axis = 2'(i);
                face_side = ax_hi[i];
            end
        end
        hit = in_box && (|ax_on);
        for (int i = 0; i < 3; i++) begin
            acc_nxt[i] = in_box ? p[i][WIDTH-1:0] : acc[i];
        end
        last_iter = (count == CNT_LAST);
    end

    // Control FSM plus datapath and result registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            acc             <= '0;
            s               <= '0;
            l_r             <= '0;
            u_r             <= '0;
            tag_r           <= '0;
            count           <= '0;
            bus.out_qp      <= '0;
            bus.out_tag     <= '0;
            bus.out_face    <= 3'b110;
            bus.out_oob     <= 1'b0;
            bus.out_timeout <= 1'b0;
            bus.out_iters   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        acc   <= bus.in_q;
                        l_r   <= bus.in_l;
                        u_r   <= bus.in_u;
                        tag_r <= bus.in_tag;
                        count <= '0;
                        for (int i = 0; i < 3; i++) begin
                            s[i] <= {bus.in_v[i], 1'b0};
                        end
                        state <= STEP;
                    end
                end
                STEP: begin
                    acc   <= acc_nxt;
                    count <= count + CNT_ONE;
                    for (int i = 0; i < 3; i++) begin
                        s[i] <= {s[i][WIDTH], s[i][WIDTH:1]};
                    end
                    // A hit on the final iteration wins over the timeout.
                    if (hit) begin
                        state           <= DONE;
                        bus.out_qp      <= acc_nxt;
                        bus.out_tag     <= tag_r;
                        bus.out_face    <= {face_axis, face_side};
                        bus.out_oob     <= oob;
                        bus.out_timeout <= 1'b0;
                        bus.out_iters   <= count + CNT_ONE;
                    end else if (last_iter) begin
                        state           <= DONE;
                        bus.out_qp      <= acc_nxt;
                        bus.out_tag     <= tag_r;
                        bus.out_face    <= 3'b110;
                        bus.out_oob     <= 1'b0;
                        bus.out_timeout <= 1'b1;
                        bus.out_iters   <= count + CNT_ONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aabb_exit_stepper.sv
// tb/tb_aabb_exit_stepper.sv - directed self-checking bench for aabb_exit_stepper
module tb_aabb_exit_stepper;
    localparam int WIDTH    = 16;
    localparam int TAG_W    = 8;
    localparam int MAX_ITER = 18;
    localparam int CW       = 5;

    logic clock;
    logic reset;

    aabb_exit_stepper_if #(.WIDTH(WIDTH), .TAG_W(TAG_W), .CW(CW)) bus ();

    aabb_exit_stepper #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    int errors = 0;
    int checks = 0;
    int results = 0;
    bit exp_pending = 0;

    int r_q[3];
    int r_v[3];
    int r_l[3];
    int r_u[3];
    int exp_qp[3];
    int exp_face;
    int exp_oob;
    int exp_tmo;
    int exp_iters;
    int exp_tag;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Reference: ray walk in plain integers, s halves with truncation toward zero.
    task automatic compute_model();
        int acc[3];
        int s[3];
        int p[3];
        bit inbox;
        int face;
        int side;
        acc = r_q;
        for (int i = 0; i < 3; i++) s[i] = 2 * r_v[i];
        for (int it = 1; it <= MAX_ITER; it++) begin
            inbox = 1;
            face = -1;
            side = 0;
            for (int i = 0; i < 3; i++) begin
                p[i] = acc[i] + s[i] / 2;
                if (p[i] < r_l[i] - 1 || p[i] > r_u[i] + 1) inbox = 0;
                if (face < 0 && (p[i] == r_l[i] - 1 || p[i] == r_u[i] + 1)) begin
                    face = i;
                    side = (p[i] == r_u[i] + 1) ? 1 : 0;
                end
            end
            if (inbox) acc = p;
            for (int i = 0; i < 3; i++) s[i] = s[i] >>> 1;
            if (inbox && face >= 0) begin
                exp_iters = it;
                exp_tmo = 0;
                exp_face = face * 2 + side;
                exp_oob = 0;
                for (int i = 0; i < 3; i++) begin
                    exp_qp[i] = p[i] & 32'hFFFF;
                    if (p[i] < 0 || p[i] > 65535) exp_oob = 1;
                end
                return;
            end
        end
        exp_iters = MAX_ITER;
        exp_tmo = 1;
        exp_face = 6;
        exp_oob = 0;
        exp_qp = acc;
    endtask

    task automatic set_ray(input int q0, q1, q2, v0, v1, v2, lb, ub);
        r_q = '{q0, q1, q2};
        r_v = '{v0, v1, v2};
        r_l = '{lb, lb, lb};
        r_u = '{ub, ub, ub};
        compute_model();
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic drive_ray(input int tg);
        for (int i = 0; i < 3; i++) begin
            bus.in_q[i] = 16'(r_q[i]);
            bus.in_v[i] = 16'(r_v[i]);
            bus.in_l[i] = 16'(r_l[i]);
            bus.in_u[i] = 16'(r_u[i]);
        end
        bus.in_tag = 8'(tg);
        bus.in_valid = 1'b1;
    endtask

    task automatic scramble_inputs();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.in_q[i] = 16'($urandom);
            bus.in_v[i] = 16'($urandom);
            bus.in_l[i] = 16'($urandom);
            bus.in_u[i] = 16'($urandom);
        end
        bus.in_tag = 8'($urandom);
    endtask

    // Issue the current ray, wait for its result, optionally hold off the consumer.
    task automatic run_ray(input int tg, input int hold);
        int cyc;
        int base;
        bit seen;
        exp_tag = tg & 8'hFF;
        exp_pending = 1;
        base = results;
        bus.out_ready = (hold == 0);
        drive_ray(tg);
        #1;
        check("in_ready_idle", bus.in_ready, 1);
        @(posedge clock);
        #1;
        scramble_inputs();
        cyc = 1;
        seen = 0;
        while (cyc < 60 && !seen) begin
            if (bus.out_valid) seen = 1;
            else begin
                @(posedge clock);
                #1;
                cyc++;
            end
        end
        if (!seen) begin
            check("result_wait_bound", 0, 1);
            exp_pending = 0;
            pulse_reset();
            return;
        end
        check("latency", cyc, exp_iters + 1);
        if (hold > 0) begin
            repeat (hold) @(posedge clock);
            #1;
            check("held_valid", bus.out_valid, 1);
            check("held_in_ready", bus.in_ready, 0);
            bus.out_ready = 1'b1;
        end
        @(posedge clock);
        #1;
        check("idle_after_accept", bus.in_ready, 1);
        check("valid_dropped", bus.out_valid, 0);
        exp_pending = 0;
        check("one_result", results - base, 1);
    endtask

    // Output checker: every cycle a result is presented it must match the model.
    always @(negedge clock) begin
        if (!reset && bus.out_valid) begin
            if (!exp_pending) begin
                check("unexpected_result", 1, 0);
            end else begin
                check("qp_x", bus.out_qp[0], exp_qp[0]);
                check("qp_y", bus.out_qp[1], exp_qp[1]);
                check("qp_z", bus.out_qp[2], exp_qp[2]);
                check("tag", bus.out_tag, exp_tag);
                check("face", bus.out_face, exp_face);
                check("oob", bus.out_oob, exp_oob);
                check("timeout", bus.out_timeout, exp_tmo);
                check("iters", bus.out_iters, exp_iters);
                check("in_ready_busy", bus.in_ready, 0);
            end
            if (bus.out_ready) results++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        bus.out_ready = 1'b1;
        scramble_inputs();
        @(posedge clock);
        #1;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_oob", bus.out_oob, 0);
        check("rst_timeout", bus.out_timeout, 0);
        check("rst_face", bus.out_face, 6);
        check("rst_iters", bus.out_iters, 0);
        check("rst_qp_x", bus.out_qp[0], 0);
        check("rst_tag", bus.out_tag, 0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;

        set_ray(150, 150, 150, 16384, 0, 0, 100, 200);
        check("model_a_qp", exp_qp[0], 201);
        check("model_a_face", exp_face, 1);
        check("model_a_iters", exp_iters, 15);
        run_ray(8'h11, 0);

        set_ray(150, 150, 150, -16384, 0, 0, 100, 200);
        check("model_b_qp", exp_qp[0], 99);
        check("model_b_face", exp_face, 0);
        run_ray(8'h22, 0);

        set_ray(150, 150, 150, 28672, 0, 0, 100, 200);
        check("model_c_tmo", exp_tmo, 1);
        check("model_c_qp", exp_qp[0], 200);
        check("model_c_iters", exp_iters, 18);
        run_ray(8'h33, 0);

        set_ray(65520, 0, 0, 16384, 0, 0, 0, 65535);
        check("model_d_qp", exp_qp[0], 0);
        check("model_d_oob", exp_oob, 1);
        check("model_d_iters", exp_iters, 11);
        run_ray(8'h44, 0);

        set_ray(150, 150, 150, 16384, 0, 0, 100, 200);
        run_ray(8'h55, 10);

        set_ray(150, 150, 150, 0, 16384, -16384, 100, 200);
        check("model_e_face", exp_face, 3);
        check("model_e_qp_z", exp_qp[2], 99);
        run_ray(8'h66, 0);

        set_ray(200, 150, 150, 1, 0, 0, 100, 200);
        check("model_f_iters", exp_iters, 1);
        run_ray(8'h77, 0);

        set_ray(100, 100, 100, 0, 0, 0, 100, 200);
        check("model_g_face", exp_face, 6);
        run_ray(8'h88, 0);

        set_ray(150, 120, 180, 16384, -16384, 256, 100, 200);
        run_ray(8'h99, 0);

        // Reset during the fifth STEP cycle discards the ray.
        set_ray(150, 150, 150, 16384, 0, 0, 100, 200);
        exp_pending = 0;
        bus.out_ready = 1'b1;
        drive_ray(8'hAA);
        @(posedge clock);
        #1;
        scramble_inputs();
        repeat (4) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        check("mid_rst_in_ready", bus.in_ready, 1);
        check("mid_rst_out_valid", bus.out_valid, 0);
        @(negedge clock);
        reset = 1'b0;
        repeat (25) @(posedge clock);
        #1;
        check("no_result_after_rst", bus.out_valid, 0);

        set_ray(150, 150, 150, -16384, 0, 0, 100, 200);
        run_ray(8'hBB, 0);

        repeat (3) @(posedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
